truth_table_eval: RTL and testbench

TRUTH_TABLE_EVAL -- requirements
Module: truth_table_eval

---
 rtl/truth_table_eval.sv | 137 +++++++++++++
 tb/tb_truth_table_eval.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_eval.sv
// Programmable N-input boolean function: a 2-stage valid/ready lookup pipeline
// whose truth table can be reloaded serially without stalling the data path.
module truth_table_eval #(
  parameter int              N    = 3,
  parameter logic [2**N-1:0] INIT = 8'h31,
  parameter int              CW   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_vec,
  output logic          out_y,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  input  logic          cfg_abort,
  output logic          cfg_busy,
  input  logic          count_clr,
  output logic [CW-1:0] hit_count
);

  localparam int T  = 2**N;
  localparam int IW = N;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cfg_state_t;

  cfg_state_t    state, next_state;
  logic [IW-1:0] idx;
  logic [T-1:0]  shadow;
  logic [T-1:0]  active_table;
  logic          last_bit;
  logic          shadow_we;

  logic          a_valid;
  logic [N-1:0]  a_vec;
  logic          b_valid;
  logic [N-1:0]  b_vec;
  logic          b_y;
  logic          b_adv;

  // ---------------------------------------------------------------- pipeline
  assign b_adv     = !b_valid || out_ready;
  assign in_ready  = !a_valid || b_adv;
  assign out_valid = b_valid;
  assign out_vec   = b_vec;
  assign out_y     = b_y;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_vec   <= '0;
      b_valid <= 1'b0;
      b_vec   <= '0;
      b_y     <= 1'b0;
    end else begin
      if (in_ready) begin
        a_valid <= in_valid;
        if (in_valid) a_vec <= in_vec;
      end
      // B only reloads when its contents have been taken, which keeps the
      // output stable under backpressure.
      if (b_adv) begin
        b_valid <= a_valid;
        if (a_valid) begin
          b_vec <= a_vec;
          b_y   <= active_table[a_vec];
        end
      end
    end
  end

  // ------------------------------------------------------------- hit counter
  always_ff @(posedge clk) begin
    if (!reset_n || count_clr) begin
      hit_count <= '0;
    end else if (out_valid && out_ready && out_y && (hit_count != '1)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

  // -------------------------------------------------------------- config FSM
  assign last_bit = (idx == IW'(T - 1));
  assign cfg_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (cfg_valid) next_state = SHIFT;
      SHIFT: begin
        if (cfg_abort)                  next_state = IDLE;
        else if (cfg_valid && last_bit) next_state = COMMIT;
      end
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx          <= '0;
      active_table <= INIT;
    end else begin
      case (state)
        IDLE:   if (cfg_valid) idx <= IW'(1);
        SHIFT: begin
          // The last write wraps idx back to 0, ready for the next load.
          if (cfg_abort)      idx <= '0;
          else if (cfg_valid) idx <= idx + 1'b1;
        end
        COMMIT: active_table <= shadow;
        default: idx <= '0;
      endcase
    end
  end

  // idx is always 0 in IDLE, so the first bit lands in shadow[0].
  assign shadow_we = cfg_valid && ((state == IDLE) || ((state == SHIFT) && !cfg_abort));

  // NOTE: the shadow table has no reset; every bit is rewritten before any
  // commit, so stale contents can never reach active_table.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow[idx] <= cfg_bit;
  end

endmodule

// File: tb/tb_truth_table_eval.sv
// Directed bench for truth_table_eval: pipeline, backpressure, serial table
// load/abort, counter saturation and reset, with hand-computed expectations.
module tb_truth_table_eval;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_y;
  logic [2:0] in_vec, out_vec;
  logic       cfg_valid, cfg_bit, cfg_abort, cfg_busy, count_clr;
  logic [7:0] hit_count;

  logic       in_ready2, out_valid2, out_y2, cfg_busy2;
  logic [2:0] out_vec2;
  logic [1:0] hit_count2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  truth_table_eval dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_y(out_y),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort), .cfg_busy(cfg_busy),
    .count_clr(count_clr), .hit_count(hit_count)
  );

  truth_table_eval #(.CW(2)) dut_cw2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in_vec(in_vec),
    .out_valid(out_valid2), .out_ready(out_ready), .out_vec(out_vec2), .out_y(out_y2),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort), .cfg_busy(cfg_busy2),
    .count_clr(count_clr), .hit_count(hit_count2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid  = 1'b0;
    in_vec    = 3'd0;
    out_ready = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    cfg_abort = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    vectors++; if (out_vec !== 3'd0) begin miscompares++; $display("FAIL reset out_vec: got %0d exp 0", out_vec); end
    vectors++; if (out_y !== 1'b0) begin miscompares++; $display("FAIL reset out_y: got %b exp 0", out_y); end
    vectors++; if (hit_count !== 8'd0) begin miscompares++; $display("FAIL reset hit_count: got %0d exp 0", hit_count); end
    vectors++; if (cfg_busy !== 1'b0) begin miscompares++; $display("FAIL reset cfg_busy: got %b exp 0", cfg_busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
    reset_n = 1'b1;
  endtask

  // INIT=8'h31: vectors 000,100,101,111 -> 1,1,1,0
  task automatic test_stream;
    logic [2:0] sv [4] = '{3'd0, 3'd4, 3'd5, 3'd7};
    logic       ey [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int e = 0; e < 6; e++) begin
      in_valid = (e < 4);
      if (e < 4) in_vec = sv[e];
      tick();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream in_ready[%0d]: got %b exp 1", e, in_ready); end
      if (e == 0 || e == 5) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream out_valid[%0d]: got %b exp 0", e, out_valid); end
      end else begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream out_valid[%0d]: got %b exp 1", e, out_valid); end
        vectors++; if (out_vec !== sv[e-1]) begin miscompares++; $display("FAIL stream out_vec[%0d]: got %0d exp %0d", e, out_vec, sv[e-1]); end
        vectors++; if (out_y !== ey[e-1]) begin miscompares++; $display("FAIL stream out_y[%0d]: got %b exp %b", e, out_y, ey[e-1]); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (hit_count !== 8'd3) begin miscompares++; $display("FAIL stream hit_count: got %0d exp 3", hit_count); end
  endtask

  // INIT=8'h31: vectors 1..6 -> 0,0,0,1,1,0
  task automatic test_backpressure;
    logic [2:0] v  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic       ey [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   sent = 0;
    int   recv = 0;
    logic ir, ov, oy;
    logic [2:0] ovec;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_vec   = v[sent];
      #1;
      ir = in_ready;
      @(posedge clk);
      if (ir) sent++;
      #1;
      if (c >= 1) begin
        vectors++; if (out_valid !== 1'b1 || out_vec !== v[0]) begin miscompares++; $display("FAIL stall hold[%0d]: got valid=%b vec=%0d exp valid=1 vec=%0d", c, out_valid, out_vec, v[0]); end
      end
    end
    vectors++; if (sent != 2) begin miscompares++; $display("FAIL stall accepts: got %0d exp 2", sent); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall in_ready: got %b exp 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && recv < 6; c++) begin
      in_valid = (sent < 6);
      if (sent < 6) in_vec = v[sent];
      #1;
      ir = in_ready; ov = out_valid; ovec = out_vec; oy = out_y;
      @(posedge clk);
      if (in_valid && ir) sent++;
      if (ov) begin
        vectors++;
        if (recv >= 6) begin
          miscompares++; $display("FAIL release extra output: got vec=%0d exp none", ovec);
        end else if (ovec !== v[recv] || oy !== ey[recv]) begin
          miscompares++; $display("FAIL release order[%0d]: got vec=%0d y=%b exp vec=%0d y=%b", recv, ovec, oy, v[recv], ey[recv]);
        end
        recv++;
      end
      #1;
    end
    in_valid = 1'b0;
    vectors++; if (recv != 6) begin miscompares++; $display("FAIL release count: got %0d exp 6", recv); end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
    end
    vectors++; if (cfg_busy !== 1'b1) begin miscompares++; $display("FAIL abort busy before: got %b exp 1", cfg_busy); end
    cfg_abort = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    vectors++; if (cfg_busy !== 1'b0) begin miscompares++; $display("FAIL abort busy after: got %b exp 0", cfg_busy); end
    tick();
    vectors++; if (cfg_busy !== 1'b0) begin miscompares++; $display("FAIL abort busy settle: got %b exp 0", cfg_busy); end
    in_valid = 1'b1;
    in_vec   = 3'd0;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_y !== 1'b1) begin miscompares++; $display("FAIL abort table: got valid=%b y=%b exp valid=1 y=1", out_valid, out_y); end
    tick();
  endtask

  // Load 8'h80: only vector 111 maps to 1. A vector crossing A->B on the
  // commit edge still sees the old table (000 -> 1).
  task automatic test_load;
    logic [7:0] tbl = 8'h80;
    int busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = tbl[i];
      in_valid  = (i == 7);
      in_vec    = 3'd0;
      tick();
      if (cfg_busy) busy_cnt++;
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    tick();
    if (cfg_busy) busy_cnt++;
    vectors++; if (cfg_busy !== 1'b0) begin miscompares++; $display("FAIL load busy after commit: got %b exp 0", cfg_busy); end
    vectors++; if (out_valid !== 1'b1 || out_vec !== 3'd0 || out_y !== 1'b1) begin miscompares++; $display("FAIL load commit-edge old table: got valid=%b vec=%0d y=%b exp 1 0 1", out_valid, out_vec, out_y); end
    in_valid = 1'b1;
    in_vec   = 3'd7;
    tick();
    if (cfg_busy) busy_cnt++;
    in_vec = 3'd0;
    tick();
    if (cfg_busy) busy_cnt++;
    in_valid = 1'b0;
    vectors++; if (out_vec !== 3'd7 || out_y !== 1'b1) begin miscompares++; $display("FAIL load new table 111: got vec=%0d y=%b exp 7 1", out_vec, out_y); end
    tick();
    vectors++; if (out_vec !== 3'd0 || out_y !== 1'b0) begin miscompares++; $display("FAIL load new table 000: got vec=%0d y=%b exp 0 0", out_vec, out_y); end
    vectors++; if (busy_cnt != 8) begin miscompares++; $display("FAIL load busy cycles: got %0d exp 8", busy_cnt); end
    tick();
  endtask

  // Table is 8'h80 here, so 111 is a hit.
  task automatic test_saturation;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    vectors++; if (hit_count !== 8'd0 || hit_count2 !== 2'd0) begin miscompares++; $display("FAIL sat clear: got %0d/%0d exp 0/0", hit_count, hit_count2); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_vec   = 3'd7;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    vectors++; if (hit_count !== 8'd5) begin miscompares++; $display("FAIL sat cw8 count: got %0d exp 5", hit_count); end
    vectors++; if (hit_count2 !== 2'd3) begin miscompares++; $display("FAIL sat cw2 count: got %0d exp 3", hit_count2); end
    in_valid = 1'b1;
    in_vec   = 3'd7;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_y !== 1'b1) begin miscompares++; $display("FAIL sat pending hit: got valid=%b y=%b exp 1 1", out_valid, out_y); end
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    vectors++; if (hit_count !== 8'd0 || hit_count2 !== 2'd0) begin miscompares++; $display("FAIL sat clr priority: got %0d/%0d exp 0/0", hit_count, hit_count2); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 3'd0;
    tick();
    in_vec = 3'd7;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || cfg_busy !== 1'b1) begin miscompares++; $display("FAIL midreset setup: got valid=%b busy=%b exp 1 1", out_valid, cfg_busy); end
    reset_n   = 1'b0;
    cfg_valid = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset out_valid: got %b exp 0", out_valid); end
    vectors++; if (cfg_busy !== 1'b0) begin miscompares++; $display("FAIL midreset cfg_busy: got %b exp 0", cfg_busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset in_ready: got %b exp 1", in_ready); end
    reset_n   = 1'b1;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 3'd0;
    tick();
    in_vec = 3'd7;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_vec !== 3'd0 || out_y !== 1'b1) begin miscompares++; $display("FAIL midreset INIT 000: got vec=%0d y=%b exp 0 1", out_vec, out_y); end
    tick();
    vectors++; if (out_vec !== 3'd7 || out_y !== 1'b0) begin miscompares++; $display("FAIL midreset INIT 111: got vec=%0d y=%b exp 7 0", out_vec, out_y); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset dropped: got valid=%b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_load();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

endmodule
